// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial word link (sender and receiver sides).
// Holds the receiver state encoding, default link geometry and the word type.
package serial_link_pkg;

  localparam int SL_WORD_SIZE = 27;
  localparam int SL_NUM_WORDS = 4;

  typedef logic [SL_WORD_SIZE-1:0] word_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with a registered head word; a push that would overfill is
// accepted only when a pop frees a slot on the same edge.
module word_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             push_acc;
  logic             pop_acc;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);
  assign rd_next  = pop_acc ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr] <= din;
  end

  // Head register: when the new head is the slot being written this edge, take din directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      dout <= (push_acc && (rd_next == wr_ptr)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Frame-aligned MSB-first deserialiser feeding a valid/ready output FIFO.
// Optional per-word even-parity check enabled by SERIAL_RX_PARITY_CHECK_EN.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WORD_SIZE = SL_WORD_SIZE,
  parameter int NUM_WORDS = SL_NUM_WORDS,
  parameter int DEPTH     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   serialIn,
  input  logic                   start,
  output logic                   busy,
  output logic                   msg_done,
  output logic [WORD_SIZE-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_perr,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int BCW = $clog2(WORD_SIZE);
  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_SIZE - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_WORDS - 1);
`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam int FW = WORD_SIZE + 1;
`else
  localparam int FW = WORD_SIZE;
`endif

  rx_state_t            state_q;
  rx_state_t            state_d;
  logic [BCW-1:0]       bit_cnt;
  logic [WCW-1:0]       word_cnt;
  logic [WORD_SIZE-2:0] shreg;
  logic [WORD_SIZE-1:0] word_in;
  logic                 word_end;
  logic                 last_word;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FW-1:0]        fifo_din;
  logic [FW-1:0]        fifo_dout;

  assign word_in   = {shreg, serialIn};
  assign word_end  = (state_q == RX_SHIFT) && (bit_cnt == '0);
  assign last_word = word_end && (word_cnt == WORD_LAST);
  assign pop       = out_valid & out_ready;
  assign busy      = (state_q == RX_SHIFT);
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_dout[WORD_SIZE-1:0];

`ifdef SERIAL_RX_PARITY_CHECK_EN
  assign fifo_din = {^word_in, word_in};
  assign out_perr = fifo_dout[FW-1];
`else
  assign fifo_din = word_in;
  assign out_perr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (start) state_d = RX_SHIFT;
      RX_SHIFT: if (last_word) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      bit_cnt  <= BIT_LAST;
      word_cnt <= '0;
      msg_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_done <= last_word;
      if (state_q == RX_SHIFT) begin
        bit_cnt <= word_end ? BIT_LAST : bit_cnt - 1'b1;
        if (word_end) word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
      // A new message clears the sticky drop flag; a word with nowhere to go sets it.
      if (state_q == RX_IDLE && start) overflow <= 1'b0;
      else if (word_end && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == RX_SHIFT) shreg <= word_in[WORD_SIZE-2:0];
  end

  word_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (word_end),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WORD_SIZE=27, NUM_WORDS=4, DEPTH=4).
module tb_serial_word_receiver;

  logic        clock;
  logic        reset;
  logic        serialIn;
  logic        start;
  logic        busy;
  logic        msg_done;
  logic [26:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_perr;
  logic        overflow;
  logic [2:0]  fifo_count;

  int          n_err = 0;
  int          n_chk = 0;
  int          done_cnt = 0;
  logic [26:0] exp_q[$];

`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam logic PERR_ODD = 1'b1;
`else
  localparam logic PERR_ODD = 1'b0;
`endif

  serial_word_receiver #(
    .WORD_SIZE (27),
    .NUM_WORDS (4),
    .DEPTH     (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .serialIn   (serialIn),
    .start      (start),
    .busy       (busy),
    .msg_done   (msg_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_perr   (out_perr),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scores a pop that the coming edge will perform, then advances one cycle.
  task automatic tick();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", {37'd0, out_data}, 64'hDEAD);
      else check("pop_data", {37'd0, out_data}, {37'd0, exp_q.pop_front()});
    end
    @(posedge clock);
    #1;
    if (msg_done) done_cnt++;
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    serialIn = 1'b0;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_word(input logic [26:0] w, input int start_at);
    for (int i = 26; i >= 0; i--) begin
      serialIn = w[i];
      start    = (i == start_at);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    serialIn  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    do_reset();

    check("rst_busy", busy, 0);
    check("rst_msg_done", msg_done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", fifo_count, 0);
    check("rst_perr", out_perr, 0);

    // single word, consumer stalled
    pulse_start();
    check("t1_busy_shift", busy, 1);
    send_word(27'h1234567, -1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 27'h1234567);
    check("t1_count", fifo_count, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_data_stable", out_data, 27'h1234567);
    do_reset();
    check("t1_rst_valid", out_valid, 0);
    check("t1_rst_count", fifo_count, 0);
    check("t1_rst_busy", busy, 0);

    // full message streamed straight through
    out_ready = 1'b1;
    done_cnt  = 0;
    exp_q = '{27'h0000001, 27'h7FFFFFF, 27'h2AAAAAA, 27'h5555555};
    pulse_start();
    send_word(27'h0000001, -1);
    send_word(27'h7FFFFFF, -1);
    send_word(27'h2AAAAAA, -1);
    send_word(27'h5555555, -1);
    check("t2_msg_done", msg_done, 1);
    check("t2_busy", busy, 0);
    repeat (3) tick();
    check("t2_all_popped", exp_q.size(), 0);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_overflow", overflow, 0);
    check("t2_count", fifo_count, 0);

    // overflow: fill FIFO, then a further word is dropped
    out_ready = 1'b0;
    exp_q = '{27'h0000011, 27'h0000022, 27'h0000033, 27'h0000044};
    pulse_start();
    send_word(27'h0000011, -1);
    send_word(27'h0000022, -1);
    send_word(27'h0000033, -1);
    send_word(27'h0000044, -1);
    check("t3_count_full", fifo_count, 4);
    check("t3_no_ovf_yet", overflow, 0);
    pulse_start();
    send_word(27'h1111111, -1);
    check("t3_overflow", overflow, 1);
    check("t3_count_kept", fifo_count, 4);
    check("t3_head_kept", out_data, 27'h0000011);
    out_ready = 1'b1;
    exp_q.push_back(27'h0000066);
    send_word(27'h0000066, -1);
    exp_q.push_back(27'h0000077);
    send_word(27'h0000077, -1);
    exp_q.push_back(27'h0000088);
    send_word(27'h0000088, -1);
    repeat (3) tick();
    check("t3_all_popped", exp_q.size(), 0);
    check("t3_ovf_sticky", overflow, 1);
    pulse_start();
    check("t3_ovf_cleared", overflow, 0);
    do_reset();

    // reset mid-word discards partial and buffered words
    out_ready = 1'b0;
    pulse_start();
    send_word(27'h0000123, -1);
    for (int i = 26; i >= 17; i--) begin
      serialIn = 1'b1;
      tick();
    end
    do_reset();
    check("t4_busy", busy, 0);
    check("t4_valid", out_valid, 0);
    check("t4_count", fifo_count, 0);
    check("t4_data", out_data, 0);
    check("t4_msg_done", msg_done, 0);
    pulse_start();
    send_word(27'h0ABCDEF, -1);
    check("t4_new_data", out_data, 27'h0ABCDEF);
    check("t4_new_count", fifo_count, 1);
    do_reset();

    // start mid-word is ignored
    out_ready = 1'b1;
    done_cnt  = 0;
    exp_q = '{27'h3C3C3C3, 27'h4D4D4D4, 27'h0F0F0F0, 27'h6060606};
    pulse_start();
    send_word(27'h3C3C3C3, -1);
    send_word(27'h4D4D4D4, 13);
    check("t5_busy_mid", busy, 1);
    send_word(27'h0F0F0F0, -1);
    send_word(27'h6060606, -1);
    check("t5_idle", busy, 0);
    repeat (3) tick();
    check("t5_all_popped", exp_q.size(), 0);
    check("t5_done_pulses", done_cnt, 1);
    do_reset();

    // parity flag
    out_ready = 1'b0;
    pulse_start();
    send_word(27'h0000003, -1);
    check("t6_perr_even", out_perr, 0);
    do_reset();
    pulse_start();
    send_word(27'h0000001, -1);
    check("t6_perr_odd", out_perr, PERR_ODD);
    check("t6_data_full", out_data, 27'h0000001);
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
